// File: rtl/eth_tx_tile_pkg.sv
// Shared types and field layout for the Ethernet TX tile.
// Flit fields are MSB-first; offsets count down from the flit MSB.
package eth_tx_tile_pkg;

    localparam int MAC_W         = 48;
    localparam int ETH_TYPE_W    = 16;
    localparam int PAYLOAD_LEN_W = 16;
    localparam int MSG_LEN_W     = 8;

    localparam int MSG_LEN_OFF     = 0;
    localparam int DST_MAC_OFF     = 0;
    localparam int SRC_MAC_OFF     = DST_MAC_OFF + MAC_W;
    localparam int ETH_TYPE_OFF    = SRC_MAC_OFF + MAC_W;
    localparam int PAYLOAD_LEN_OFF = ETH_TYPE_OFF + ETH_TYPE_W;
    localparam int META_W          = PAYLOAD_LEN_OFF + PAYLOAD_LEN_W;

    typedef enum logic [1:0] {
        READY,
        META,
        HDR_OUT,
        DATA
    } state_e;

    typedef struct packed {
        logic [MSG_LEN_W-1:0] msg_len;
    } hdr_flit_t;

    typedef struct packed {
        logic [MAC_W-1:0]         dst_mac;
        logic [MAC_W-1:0]         src_mac;
        logic [ETH_TYPE_W-1:0]    eth_type;
        logic [PAYLOAD_LEN_W-1:0] payload_len;
    } meta_flit_t;

endpackage

// File: rtl/eth_tx_noc_in_datap.sv
// Field capture, flit counter and trailing pad computation
// for the TX NoC ingress controller.
module eth_tx_noc_in_datap
    import eth_tx_tile_pkg::*;
#(
    parameter int NOC_DATA_W = 512,
    parameter int FLIT_CNT_W = 8,
    parameter int PAD_W      = $clog2(NOC_DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_hdr,
    input  logic [FLIT_CNT_W-1:0] msg_len,
    input  logic                  load_meta,
    input  meta_flit_t            meta,
    input  logic                  dec,
    output logic [FLIT_CNT_W-1:0] flits_rem,
    output meta_flit_t            meta_q,
    output logic [PAD_W-1:0]      padbytes_q
);

    localparam int BYTES = NOC_DATA_W / 8;

    logic [PAYLOAD_LEN_W-1:0] tail;
    logic [PAD_W-1:0]         pad_nxt;

    // Bytes left unused in the final flit of the payload.
    always_comb begin
        tail    = meta.payload_len % PAYLOAD_LEN_W'(BYTES);
        pad_nxt = '0;
        if (tail != '0)
            pad_nxt = PAD_W'(PAYLOAD_LEN_W'(BYTES) - tail);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flits_rem  <= '0;
            meta_q     <= '0;
            padbytes_q <= '0;
        end else begin
            if (load_hdr)
                flits_rem <= msg_len - FLIT_CNT_W'(1);
            else if (dec)
                flits_rem <= flits_rem - FLIT_CNT_W'(1);
            if (load_meta) begin
                meta_q     <= meta;
                padbytes_q <= pad_nxt;
            end
        end
    end

endmodule

// File: rtl/eth_tx_noc_in_ctrl.sv
// TX tile NoC ingress: header + metadata + data flits in,
// one Ethernet header transaction plus a data stream out.
module eth_tx_noc_in_ctrl
    import eth_tx_tile_pkg::*;
#(
    parameter int NOC_DATA_W = 512,
    parameter int FLIT_CNT_W = 8,
    parameter int PAD_W      = $clog2(NOC_DATA_W / 8)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     noc0_ctovr_eth_tx_in_val,
    input  logic [NOC_DATA_W-1:0]    noc0_ctovr_eth_tx_in_data,
    output logic                     eth_tx_in_noc0_ctovr_rdy,
    output logic                     eth_tx_in_eth_format_hdr_val,
    output logic [MAC_W-1:0]         eth_tx_in_eth_format_dst_mac,
    output logic [MAC_W-1:0]         eth_tx_in_eth_format_src_mac,
    output logic [ETH_TYPE_W-1:0]    eth_tx_in_eth_format_eth_type,
    output logic [PAYLOAD_LEN_W-1:0] eth_tx_in_eth_format_payload_len,
    input  logic                     eth_format_eth_tx_in_hdr_rdy,
    output logic                     eth_tx_in_eth_format_data_val,
    output logic [NOC_DATA_W-1:0]    eth_tx_in_eth_format_data,
    output logic                     eth_tx_in_eth_format_data_last,
    output logic [PAD_W-1:0]         eth_tx_in_eth_format_data_padbytes,
    input  logic                     eth_format_eth_tx_in_data_rdy
);

    state_e                state;
    meta_flit_t            meta_in;
    meta_flit_t            meta_q;
    logic [FLIT_CNT_W-1:0] msg_len;
    logic [FLIT_CNT_W-1:0] flits_rem;
    logic [PAD_W-1:0]      padbytes_q;
    logic                  noc_rdy;
    logic                  noc_hs;
    logic                  last;
    logic                  load_hdr;
    logic                  load_meta;
    logic                  dec;

    assign meta_in = meta_flit_t'(noc0_ctovr_eth_tx_in_data[NOC_DATA_W-1 -: META_W]);
    assign msg_len = noc0_ctovr_eth_tx_in_data[NOC_DATA_W-1 -: FLIT_CNT_W];

    always_comb begin
        noc_rdy = 1'b0;
        unique case (state)
            READY:   noc_rdy = 1'b1;
            META:    noc_rdy = 1'b1;
            HDR_OUT: noc_rdy = 1'b0;
            DATA:    noc_rdy = eth_format_eth_tx_in_data_rdy;
        endcase
        if (rst)
            noc_rdy = 1'b0;
    end

    assign noc_hs    = noc0_ctovr_eth_tx_in_val && noc_rdy;
    assign last      = (state == DATA) && (flits_rem == FLIT_CNT_W'(1));
    // A zero-length header is swallowed without touching the counter.
    assign load_hdr  = (state == READY) && noc_hs && (msg_len != '0);
    assign load_meta = (state == META) && noc_hs;
    assign dec       = (state == DATA) && noc_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= READY;
        end else begin
            unique case (state)
                READY:   if (load_hdr) state <= META;
                META:    if (noc_hs) state <= HDR_OUT;
                HDR_OUT: if (eth_format_eth_tx_in_hdr_rdy)
                             state <= (flits_rem != '0) ? DATA : READY;
                DATA:    if (noc_hs && last) state <= READY;
            endcase
        end
    end

    eth_tx_noc_in_datap #(
        .NOC_DATA_W (NOC_DATA_W),
        .FLIT_CNT_W (FLIT_CNT_W),
        .PAD_W      (PAD_W)
    ) u_datap (
        .clk        (clk),
        .rst        (rst),
        .load_hdr   (load_hdr),
        .msg_len    (msg_len),
        .load_meta  (load_meta),
        .meta       (meta_in),
        .dec        (dec),
        .flits_rem  (flits_rem),
        .meta_q     (meta_q),
        .padbytes_q (padbytes_q)
    );

    assign eth_tx_in_noc0_ctovr_rdy           = noc_rdy;
    assign eth_tx_in_eth_format_hdr_val       = !rst && (state == HDR_OUT);
    assign eth_tx_in_eth_format_dst_mac       = meta_q.dst_mac;
    assign eth_tx_in_eth_format_src_mac       = meta_q.src_mac;
    assign eth_tx_in_eth_format_eth_type      = meta_q.eth_type;
    assign eth_tx_in_eth_format_payload_len   = meta_q.payload_len;
    assign eth_tx_in_eth_format_data_val      = !rst && (state == DATA)
                                                && noc0_ctovr_eth_tx_in_val;
    assign eth_tx_in_eth_format_data          = noc0_ctovr_eth_tx_in_data;
    assign eth_tx_in_eth_format_data_last     = last;
    assign eth_tx_in_eth_format_data_padbytes = last ? padbytes_q : '0;

endmodule

// File: tb/tb_eth_tx_noc_in_ctrl.sv
// Bench for eth_tx_noc_in_ctrl: message table, corner sequences
// and random traffic checked against a transaction-level model.
module tb_eth_tx_noc_in_ctrl;

    localparam int W     = 512;
    localparam int FW    = 8;
    localparam int PW    = 6;
    localparam int BYTES = W / 8;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] len;
    } hdr_t;

    typedef struct {
        logic [W-1:0]  d;
        logic          last;
        logic [PW-1:0] pad;
    } dat_t;

    typedef struct {
        int msg_len;
        int plen;
        int exp_pad;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          noc_val;
    logic [W-1:0]  noc_data;
    logic          noc_rdy;
    logic          hdr_val;
    logic [47:0]   dst_mac;
    logic [47:0]   src_mac;
    logic [15:0]   eth_type;
    logic [15:0]   plen;
    logic          hdr_rdy;
    logic          data_val;
    logic [W-1:0]  data;
    logic          last;
    logic [PW-1:0] pad;
    logic          data_rdy;

    int vec, err, mon_vec, mon_err;
    int cyc, first_hs, last_hs, rdy_pct;
    int oh_i, od_i;
    hdr_t exp_hdr[$];
    dat_t exp_dat[$];
    hdr_t obs_hdr[$];
    dat_t obs_dat[$];

    eth_tx_noc_in_ctrl dut (
        .clk                                (clk),
        .rst                                (rst),
        .noc0_ctovr_eth_tx_in_val           (noc_val),
        .noc0_ctovr_eth_tx_in_data          (noc_data),
        .eth_tx_in_noc0_ctovr_rdy           (noc_rdy),
        .eth_tx_in_eth_format_hdr_val       (hdr_val),
        .eth_tx_in_eth_format_dst_mac       (dst_mac),
        .eth_tx_in_eth_format_src_mac       (src_mac),
        .eth_tx_in_eth_format_eth_type      (eth_type),
        .eth_tx_in_eth_format_payload_len   (plen),
        .eth_format_eth_tx_in_hdr_rdy       (hdr_rdy),
        .eth_tx_in_eth_format_data_val      (data_val),
        .eth_tx_in_eth_format_data          (data),
        .eth_tx_in_eth_format_data_last     (last),
        .eth_tx_in_eth_format_data_padbytes (pad),
        .eth_format_eth_tx_in_data_rdy      (data_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream sink with configurable ready probability.
    initial begin
        hdr_rdy  = 1'b0;
        data_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hdr_rdy  = ($urandom_range(99) < rdy_pct);
            data_rdy = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: protocol invariants each cycle, records accepted transfers.
    hdr_t         ph;
    logic [W-1:0] pd;
    logic         pv_h, pr_h, pv_d, pr_d;
    initial begin
        pv_h = 0; pr_h = 0; pv_d = 0; pr_d = 0;
        mon_vec = 0; mon_err = 0;
    end
    always @(negedge clk) begin
        if (rst) begin
            pv_h = 0;
            pv_d = 0;
        end else begin
            mon_vec++;
            if (hdr_val && data_val) begin
                mon_err++;
                $display("FAIL excl: hdr_val=%b data_val=%b, required not both", hdr_val, data_val);
            end
            mon_vec++;
            if (hdr_val && noc_rdy) begin
                mon_err++;
                $display("FAIL rdy_in_hdr: noc_rdy=%b, required 0 while hdr_val", noc_rdy);
            end
            mon_vec++;
            if (!last && pad != '0) begin
                mon_err++;
                $display("FAIL pad_nonlast: padbytes=%0d, required 0", pad);
            end
            if (pv_h && !pr_h) begin
                mon_vec++;
                if (!hdr_val || dst_mac != ph.dst || src_mac != ph.src ||
                    eth_type != ph.typ || plen != ph.len) begin
                    mon_err++;
                    $display("FAIL hdr_hold: hdr_val=%b dst=%h, required 1 dst=%h", hdr_val, dst_mac, ph.dst);
                end
            end
            if (pv_d && !pr_d) begin
                mon_vec++;
                if (!data_val || data != pd) begin
                    mon_err++;
                    $display("FAIL data_hold: data_val=%b d=%h, required 1 d=%h", data_val, data[31:0], pd[31:0]);
                end
            end
            if (hdr_val && hdr_rdy)
                obs_hdr.push_back('{dst_mac, src_mac, eth_type, plen});
            if (data_val && data_rdy)
                obs_dat.push_back('{data, last, pad});
            pv_h = hdr_val;
            pr_h = hdr_rdy;
            ph   = '{dst_mac, src_mac, eth_type, plen};
            pv_d = data_val;
            pr_d = data_rdy;
            pd   = data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rand_flit();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic int pad_of(input int pl);
        return (BYTES - (pl % BYTES)) % BYTES;
    endfunction

    // Present one flit and hold it until accepted (gap = idle % before it).
    task automatic send_flit(input logic [W-1:0] d, input int gap);
        int   t;
        logic hs;
        while (gap > 0 && $urandom_range(99) < gap) begin
            noc_val = 1'b0;
            tick();
        end
        noc_val  = 1'b1;
        noc_data = d;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 2000) begin
            @(negedge clk);
            hs = noc_rdy;
            tick();
            t++;
        end
        if (!hs) begin
            vec++;
            err++;
            $display("FAIL noc_accept: timeout after %0d cycles, required handshake", t);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
    endtask

    // Builds a message, records what the sink must see, sends ndata
    // data flits (all when ndata < 0).
    task automatic send_msg(input int ml, input int pl, input int xpad,
                            input int gap, input int ndata);
        logic [W-1:0] f;
        hdr_t         h;
        h.dst = 48'({$urandom(), $urandom()});
        h.src = 48'({$urandom(), $urandom()});
        h.typ = 16'($urandom());
        h.len = 16'(pl);
        if (ml != 0) exp_hdr.push_back(h);
        f = rand_flit();
        f[W-1 -: FW] = FW'(ml);
        send_flit(f, gap);
        if (ml == 0) return;
        f = rand_flit();
        f[W-1 -: 48]   = h.dst;
        f[W-49 -: 48]  = h.src;
        f[W-97 -: 16]  = h.typ;
        f[W-113 -: 16] = h.len;
        send_flit(f, gap);
        chk("hdr_latency", 32'(hdr_val), 32'd1);
        for (int i = 1; i < ml; i++) begin
            if (ndata >= 0 && i > ndata) break;
            f = rand_flit();
            exp_dat.push_back('{f, (i == ml - 1), (i == ml - 1) ? PW'(xpad) : PW'(0)});
            send_flit(f, gap);
        end
    endtask

    task automatic drain();
        int   t;
        hdr_t h;
        dat_t d;
        noc_val = 1'b0;
        t = 0;
        while ((obs_hdr.size() - oh_i < exp_hdr.size() ||
                obs_dat.size() - od_i < exp_dat.size()) && t < 2000) begin
            tick();
            t++;
        end
        repeat (4) tick();
        while (exp_hdr.size() > 0) begin
            h = exp_hdr.pop_front();
            vec++;
            if (oh_i >= obs_hdr.size()) begin
                err++;
                $display("FAIL hdr_missing: no header seen, required dst=%h", h.dst);
            end else begin
                if (obs_hdr[oh_i].dst != h.dst || obs_hdr[oh_i].src != h.src ||
                    obs_hdr[oh_i].typ != h.typ || obs_hdr[oh_i].len != h.len) begin
                    err++;
                    $display("FAIL hdr_fields: got %h/%h/%h/%0d, required %h/%h/%h/%0d",
                             obs_hdr[oh_i].dst, obs_hdr[oh_i].src, obs_hdr[oh_i].typ,
                             obs_hdr[oh_i].len, h.dst, h.src, h.typ, h.len);
                end
                oh_i++;
            end
        end
        while (exp_dat.size() > 0) begin
            d = exp_dat.pop_front();
            vec++;
            if (od_i >= obs_dat.size()) begin
                err++;
                $display("FAIL data_missing: no flit seen, required d=%h", d.d[31:0]);
            end else begin
                if (obs_dat[od_i].d != d.d || obs_dat[od_i].last != d.last ||
                    obs_dat[od_i].pad != d.pad) begin
                    err++;
                    $display("FAIL data_flit: got d=%h last=%b pad=%0d, required d=%h last=%b pad=%0d",
                             obs_dat[od_i].d[31:0], obs_dat[od_i].last, obs_dat[od_i].pad,
                             d.d[31:0], d.last, d.pad);
                end
                od_i++;
            end
        end
        chk("hdr_extra", 32'(obs_hdr.size() - oh_i), 32'd0);
        chk("data_extra", 32'(obs_dat.size() - od_i), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        int ml, pl;
        vec = 0; err = 0;
        oh_i = 0; od_i = 0;
        first_hs = -1; last_hs = 0;
        rdy_pct = 100;
        rst = 1'b1;
        noc_val = 1'b1;
        noc_data = '0;

        tbl.push_back('{3, 100, 28});
        tbl.push_back('{1, 0, 0});
        tbl.push_back('{2, 1, 63});
        tbl.push_back('{1, 200, 56});
        tbl.push_back('{4, 63, 1});
        tbl.push_back('{3, 64, 0});
        tbl.push_back('{2, 65, 63});
        tbl.push_back('{5, 511, 1});
        tbl.push_back('{2, 0, 0});

        // Reset values with a valid flit pending on the input.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_hdr_val", 32'(hdr_val), 32'd0);
        chk("rst_data_val", 32'(data_val), 32'd0);
        chk("rst_noc_rdy", 32'(noc_rdy), 32'd0);
        tick();
        rst = 1'b0;
        noc_val = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 32'(noc_rdy), 32'd1);
        tick();

        foreach (tbl[i]) send_msg(tbl[i].msg_len, tbl[i].plen, tbl[i].exp_pad, 0, -1);
        drain();

        // Zero-length header is dropped; next message proceeds normally.
        send_msg(0, 0, 0, 0, -1);
        chk("len0_hdr_val", 32'(hdr_val), 32'd0);
        chk("len0_noc_rdy", 32'(noc_rdy), 32'd1);
        send_msg(2, 10, 54, 0, -1);
        drain();

        rdy_pct = 50;
        repeat (8) send_msg(3, 128, 0, 50, -1);
        drain();

        // Reset in DATA after 1 of 4 data flits.
        rdy_pct = 100;
        tick();
        send_msg(5, 300, 20, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_hdr_val", 32'(hdr_val), 32'd0);
        chk("midrst_data_val", 32'(data_val), 32'd0);
        chk("midrst_noc_rdy", 32'(noc_rdy), 32'd0);
        tick();
        noc_val = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rdy_after", 32'(noc_rdy), 32'd1);
        tick();
        send_msg(4, 129, 63, 0, -1);
        drain();

        // Back-to-back messages: each costs msg_len + 2 cycles.
        first_hs = -1;
        send_msg(2, 70, 58, 0, -1);
        send_msg(1, 5, 59, 0, -1);
        send_msg(4, 192, 0, 0, -1);
        chk("b2b_cycles", 32'(last_hs - first_hs + 1), 32'd13);
        drain();

        rdy_pct = 50;
        repeat (40) begin
            ml = $urandom_range(6);
            pl = $urandom_range(1600);
            send_msg(ml, pl, pad_of(pl), 30, -1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec + mon_vec, err + mon_err);
        $finish;
    end

endmodule

// File: doc/eth_tx_noc_in_ctrl.md
# eth_tx_noc_in_ctrl

Transmit-side NoC ingress controller for the Ethernet TX tile. Accepts a NoC message (header flit, metadata flit, N data flits) from noc0 and converts it into one Ethernet header transaction plus a data stream with last/padbytes for the downstream Ethernet formatter. It is the counterpart of the RX tile's NoC egress control and uses the same header, metadata and data flit ordering. Control and its small datapath (field capture, flit counter) live in this block.

## Interface
- NOC_DATA_W, 512: NoC flit width in bits; must be a multiple of 8.
- FLIT_CNT_W, 8: width of the header `msg_len` field and of the flit counter.
- PAD_W, $clog2(NOC_DATA_W/8): width of `padbytes`.

- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- noc0_ctovr_eth_tx_in_val  in  1  NoC flit valid.
- noc0_ctovr_eth_tx_in_data  in  NOC_DATA_W  NoC flit.
- eth_tx_in_noc0_ctovr_rdy  out  1  NoC flit ready.
- eth_tx_in_eth_format_hdr_val  out  1  Ethernet header valid.
- eth_tx_in_eth_format_dst_mac  out  48  destination MAC.
- eth_tx_in_eth_format_src_mac  out  48  source MAC.
- eth_tx_in_eth_format_eth_type  out  16  EtherType.
- eth_tx_in_eth_format_payload_len  out  16  payload length in bytes.
- eth_format_eth_tx_in_hdr_rdy  in  1  header ready.
- eth_tx_in_eth_format_data_val  out  1  data valid.
- eth_tx_in_eth_format_data  out  NOC_DATA_W  data flit, passed through.
- eth_tx_in_eth_format_data_last  out  1  final data flit.
- eth_tx_in_eth_format_data_padbytes  out  PAD_W  invalid trailing bytes; nonzero only when last is set.
- eth_format_eth_tx_in_data_rdy  in  1  data ready.

## Operation
- Flit layouts are MSB-first.
- Header flit: `msg_len` (FLIT_CNT_W bits) counts the flits after the header, including the metadata flit.
- Metadata flit: dst_mac [W-1 -: 48], src_mac [W-49 -: 48], eth_type [W-97 -: 16], payload_len [W-113 -: 16].
- State READY:
  - noc rdy=1.
  - On header handshake: load flits_rem ← msg_len−1.
  - If msg_len=0 (malformed), stay in READY and drop the header.
  - Otherwise go to META.
- State META:
  - noc rdy=1.
  - On handshake: register the four metadata fields and padbytes_reg ← (BYTES − payload_len mod BYTES) mod BYTES, where BYTES=W/8.
  - Go to HDR_OUT.
- State HDR_OUT:
  - noc rdy=0; hdr_val=1; the header fields come from registers.
  - On hdr_rdy, go to DATA if flits_rem≠0, else to READY.
- State DATA (combinational pass-through):
  - data_val=noc val; noc rdy=data_rdy; data=noc data.
  - last = (flits_rem==1); padbytes = last ? padbytes_reg : 0.
  - On handshake, flits_rem decrements; on the last handshake go to READY.
- The flit count comes from msg_len only. payload_len is forwarded unchanged and sets padbytes only; no consistency check is made.
- hdr_val and data_val are never asserted together. noc rdy is 0 in HDR_OUT.

## Timing
- Reset: state=READY, flits_rem=0, all registered fields 0.
- Output values while rst is asserted: hdr_val=0, data_val=0, noc rdy=0.
- noc rdy=1 from the first cycle after reset deasserts.
- Reset mid-message discards the partial message; the next flit is treated as a header.
- Minimum latency from header flit accepted to hdr_val: 2 cycles. Cycle 0 is the header handshake, cycle 1 the metadata handshake, and hdr_val is asserted from cycle 2.
- Header-only message (msg_len=1): HDR_OUT returns to READY. The next header can be accepted in the cycle after the hdr handshake.
- Data throughput: 1 flit/cycle while both sides are ready.
- No bubble is inserted between the last data flit and the next message's header flit; READY is entered in the next cycle.
- Downstream ready/valid may toggle on any cycle; val is never dropped by this block without a handshake.
- flits_rem never underflows. In DATA it is ≥1.

## Structure
- Package eth_tx_tile_pkg holds:
  - state enum (READY, META, HDR_OUT, DATA, 2 bits);
  - packed structs for the header and metadata flit fields;
  - field offset localparams;
  - MAC_W=48 and ETH_TYPE_W=16.
- Single module. The optional sub-module eth_tx_noc_in_datap holds the field registers, flit counter and padbytes computation; the control FSM stays in eth_tx_noc_in_ctrl.

## Test plan
- **msg_len=3, payload_len=100, W=512, all ready:**
  - hdr out with exact MAC/type fields;
  - 2 data flits, last on the 2nd, padbytes=28;
  - noc rdy=0 only in the HDR_OUT cycle.
- **msg_len=1, payload_len=0:** one hdr transaction, no data_val; next message accepted immediately after.
- **msg_len=0:** header consumed; no hdr_val or data_val; the following valid message is processed normally.
- **payload_len=128, msg_len=3, random data_rdy and noc val gaps (50%):**
  - data order preserved, no duplicates;
  - padbytes=0 on last;
  - hdr_val held stable until hdr_rdy.
- **rst pulsed during DATA after 1 of 4 flits:** outputs match reset values; a new message sent after reset is processed with correct counts.
- **Back-to-back 3 messages, downstream always ready:** total cycles = Σ(msg_len+2), where each message costs header + metadata + HDR_OUT + data flit cycles.
